// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, data first.
// Define MEM_ARB_FAIRNESS_EN to bound fetch starvation with a data-grant streak counter.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state;
  logic   grant_d;
  logic   grant_i;
  logic   force_i;

  if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15) begin : g_bad_streak
    $error("MAX_DATA_STREAK must be in 1..15");
  end

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  logic [3:0] streak;

  assign force_i = i_req && d_req && (streak == STREAK_MAX);

  // Counts data grants that bypassed a waiting fetch; only evaluated in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (state == IDLE) begin
      if (grant_i || !i_req)
        streak <= '0;
      else if (grant_d)
        streak <= streak + 4'd1;
    end
  end
`else
  assign force_i = 1'b0;
`endif

  assign grant_d = d_req && !force_i;
  assign grant_i = i_req && !grant_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            owner     <= grant_d;
            mem_req   <= 1'b1;
            mem_we    <= grant_d & d_we;
            mem_addr  <= grant_d ? d_addr : i_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!owner)
              i_rdata <= mem_rdata[31:0];
            else if (!mem_we)
              d_rdata <= mem_rdata;
            i_done <= !owner;
            d_done <= owner;
            state  <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, a behavioural memory,
// and a monitor that checks grants and completions against queued expectations.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [31:0]   i_rdata;
  logic          i_done;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          busy;
  logic          owner;

  logic          mem_en = 1'b1;
  logic          mdl_ack = 1'b0;
  logic          man_ack = 1'b0;
  logic [DW-1:0] mdl_rdata = '0;
  logic [DW-1:0] man_rdata = '0;
  assign mem_ack   = mem_en ? mdl_ack : man_ack;
  assign mem_rdata = mem_en ? mdl_rdata : man_rdata;

  int ack_delay = 0;
  int ack_extra = 0;
  int cnt = 0;
  int hold = 0;
  int tests = 0;
  int fails = 0;
  int n_grant = 0;
  int cyc = 0;

  typedef struct {
    logic          own;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } grant_t;

  grant_t        exp_grant[$];
  logic [31:0]   exp_i[$];
  logic [DW-1:0] exp_d[$];
  grant_t        cur;
  grant_t        g;
  logic          prev_req = 1'b0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    case (a)
      64'h40:   return 64'hAAAA_BBBB_D503_201F;
      64'h80:   return 64'h1111_2222_9100_0421;
      64'h1000: return 64'h0000_0000_DEAD_BEEF;
      default:  return 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  endfunction

  task automatic push_grant(input logic o, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd);
    grant_t x;
    x.own = o; x.we = we; x.addr = a; x.wdata = wd;
    exp_grant.push_back(x);
  endtask

  // which: 0 = i_done, 1 = d_done, 2 = mem_req
  task automatic wait_sig(input int which, input int limit, input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if ((which == 0 && i_done) || (which == 1 && d_done) || (which == 2 && mem_req))
        break;
      n++;
      if (n >= limit) begin
        timeout_fail(name);
        break;
      end
    end
  endtask

  // Memory model: acks ack_delay cycles into a transaction, optionally holds ack afterwards.
  always @(negedge clk) begin
    if (mem_req && !mdl_ack) begin
      if (cnt == ack_delay) begin
        mdl_ack   = 1'b1;
        mdl_rdata = mem_val(mem_addr);
        hold      = ack_extra;
      end else begin
        cnt++;
      end
    end else if (mdl_ack && !mem_req) begin
      if (hold == 0) begin
        mdl_ack = 1'b0;
        cnt     = 0;
      end else begin
        hold--;
      end
    end else if (!mem_req) begin
      cnt = 0;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      prev_req = 1'b0;
    end else begin
      if (mem_req && !prev_req) begin
        n_grant++;
        chk("grant_expected", exp_grant.size() != 0, 1);
        if (exp_grant.size() != 0) begin
          g = exp_grant.pop_front();
          chk("grant_owner", owner, g.own);
          chk("grant_we", mem_we, g.we);
          chk("grant_addr", mem_addr, g.addr);
          if (g.we) chk("grant_wdata", mem_wdata, g.wdata);
        end
        cur.own = owner; cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata;
      end else if (mem_req) begin
        chk("mem_we_stable", mem_we, cur.we);
        chk("mem_addr_stable", mem_addr, cur.addr);
        chk("mem_wdata_stable", mem_wdata, cur.wdata);
      end
      if (i_done) begin
        chk("i_done_single", d_done, 0);
        chk("i_done_expected", exp_i.size() != 0, 1);
        if (exp_i.size() != 0) chk("i_rdata", i_rdata, exp_i.pop_front());
      end
      if (d_done) begin
        chk("d_done_expected", exp_d.size() != 0, 1);
        if (exp_d.size() != 0) chk("d_rdata", d_rdata, exp_d.pop_front());
      end
      prev_req = mem_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    int base;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_done", i_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    reset = 1'b1;

    // Lone fetch, ack in first BUSY cycle
    @(posedge clk); #1;
    ack_delay = 0;
    push_grant(1'b0, 1'b0, 64'h40, '0);
    exp_i.push_back(32'hD503_201F);
    i_addr = 64'h40; i_req = 1'b1; t0 = cyc;
    wait_sig(0, 20, "t1_i_done");
    i_req = 1'b0;
    chk("t1_latency", cyc - t0, 2);
    @(negedge clk);
    chk("t1_done_pulse", i_done, 0);

    // Simultaneous fetch and load: data first, fetch in the next IDLE
    @(posedge clk); #1;
    push_grant(1'b1, 1'b0, 64'h1000, '0);
    push_grant(1'b0, 1'b0, 64'h80, '0);
    exp_d.push_back(64'h0000_0000_DEAD_BEEF);
    exp_i.push_back(32'h9100_0421);
    i_addr = 64'h80; i_req = 1'b1;
    d_addr = 64'h1000; d_we = 1'b0; d_req = 1'b1; t0 = cyc;
    wait_sig(1, 20, "t2_d_done");
    d_req = 1'b0; t1 = cyc;
    chk("t2_d_latency", cyc - t0, 2);
    chk("t2_i_rdata_kept", i_rdata, 32'hD503_201F);
    wait_sig(0, 20, "t2_i_done");
    i_req = 1'b0;
    chk("t2_i_after_d", cyc - t1, 3);
    chk("t2_d_rdata_kept", d_rdata, 64'h0000_0000_DEAD_BEEF);

    // Store with 3-cycle ack delay
    @(posedge clk); #1;
    ack_delay = 3;
    push_grant(1'b1, 1'b1, 64'h2000, 64'h1234);
    exp_d.push_back(64'h0000_0000_DEAD_BEEF);
    d_addr = 64'h2000; d_wdata = 64'h1234; d_we = 1'b1; d_req = 1'b1; t0 = cyc;
    wait_sig(1, 20, "t3_d_done");
    d_req = 1'b0; d_we = 1'b0;
    chk("t3_latency", cyc - t0, 5);
    chk("t3_i_rdata_kept", i_rdata, 32'h9100_0421);
    ack_delay = 0;

    // Spurious ack while IDLE
    repeat (2) @(negedge clk);
    mem_en = 1'b0; man_ack = 1'b1; man_rdata = 64'h1357_9BDF_0246_8ACE;
    repeat (3) @(negedge clk);
    chk("sp_idle_busy", busy, 0);
    chk("sp_idle_mem_req", mem_req, 0);
    chk("sp_idle_i_rdata", i_rdata, 32'h9100_0421);
    chk("sp_idle_d_rdata", d_rdata, 64'h0000_0000_DEAD_BEEF);
    man_ack = 1'b0; mem_en = 1'b1;

    // Ack held high through RESP and the following IDLE
    @(posedge clk); #1;
    ack_extra = 2;
    push_grant(1'b1, 1'b0, 64'h80, '0);
    exp_d.push_back(64'h1111_2222_9100_0421);
    d_addr = 64'h80; d_req = 1'b1;
    wait_sig(1, 20, "sp_resp_d_done");
    d_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("sp_resp_busy", busy, 0);
    chk("sp_resp_d_rdata", d_rdata, 64'h1111_2222_9100_0421);
    chk("sp_resp_i_rdata", i_rdata, 32'h9100_0421);
    ack_extra = 0;

    // Both requesters held: grant order with/without fairness guard
    @(posedge clk); #1;
    base = n_grant;
    for (int k = 0; k < 20; k++) begin
`ifdef MEM_ARB_FAIRNESS_EN
      if (k % 5 == 4) begin
        push_grant(1'b0, 1'b0, 64'h100, '0);
        exp_i.push_back(32'hBAD0_BAD0);
      end else begin
        push_grant(1'b1, 1'b0, 64'h3000, '0);
        exp_d.push_back(64'hBAD0_BAD0_BAD0_BAD0);
      end
`else
      push_grant(1'b1, 1'b0, 64'h3000, '0);
      exp_d.push_back(64'hBAD0_BAD0_BAD0_BAD0);
`endif
    end
    i_addr = 64'h100; i_req = 1'b1;
    d_addr = 64'h3000; d_we = 1'b0; d_req = 1'b1;
    n = 0;
    while (n_grant - base < 20 && n < 400) begin
      @(negedge clk);
      n++;
    end
    i_req = 1'b0; d_req = 1'b0;
    if (n >= 400) timeout_fail("fair_grants");
    repeat (6) @(negedge clk);
    chk("fair_grant_count", n_grant - base, 20);
    chk("fair_i_drained", exp_i.size(), 0);
    chk("fair_d_drained", exp_d.size(), 0);

    // Reset asserted mid-transaction
    @(posedge clk); #1;
    ack_delay = 10;
    push_grant(1'b0, 1'b0, 64'h40, '0);
    i_addr = 64'h40; i_req = 1'b1;
    wait_sig(2, 20, "rst_mem_req_rise");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_busy", busy, 0);
    i_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_i_done", i_done, 0);
    chk("midrst_i_rdata", i_rdata, 0);
    chk("midrst_d_rdata", d_rdata, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    ack_delay = 1;
    push_grant(1'b0, 1'b0, 64'h80, '0);
    exp_i.push_back(32'h9100_0421);
    i_addr = 64'h80; i_req = 1'b1; t0 = cyc;
    wait_sig(0, 20, "post_rst_i_done");
    i_req = 1'b0;
    chk("post_rst_latency", cyc - t0, 3);
    repeat (3) @(negedge clk);
    chk("end_grants_drained", exp_grant.size(), 0);
    chk("end_i_drained", exp_i.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
